// File: rtl/uart_verici_kuyrugu.sv
// rtl/uart_verici_kuyrugu.sv - show-ahead transmit FIFO feeding the UART transmitter
module uart_verici_kuyrugu #(
  parameter int VERI_BIT  = 8,
  parameter int DERINLIK  = 16,
  parameter int ADRES_BIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 temizle_i,
  input  logic                 yaz_gecerli_i,
  input  logic [VERI_BIT-1:0]  yaz_veri_i,
  output logic                 yaz_hazir_o,
  output logic                 oku_gecerli_o,
  output logic [VERI_BIT-1:0]  oku_veri_o,
  input  logic                 oku_tuket_i,
  output logic                 bos_o,
  output logic                 dolu_o,
  output logic [ADRES_BIT:0]   doluluk_o,
  input  logic [ADRES_BIT:0]   esik_i,
  output logic                 esik_kesme_o,
  output logic                 tasma_o,
  output logic                 alt_tasma_o
);

  logic [VERI_BIT-1:0] bellek [DERINLIK];

  logic [ADRES_BIT:0] wr_ptr_q, wr_ptr_d;
  logic [ADRES_BIT:0] rd_ptr_q, rd_ptr_d;
  logic               tasma_q, tasma_d;
  logic               alt_tasma_q, alt_tasma_d;
  logic               esik_kesme_q, esik_kesme_d;
  logic               yaz_kabul, oku_kabul;
  logic [ADRES_BIT:0] doluluk_sonraki;

  assign bos_o  = (wr_ptr_q == rd_ptr_q);
  assign dolu_o = (wr_ptr_q[ADRES_BIT] != rd_ptr_q[ADRES_BIT]) &&
                  (wr_ptr_q[ADRES_BIT-1:0] == rd_ptr_q[ADRES_BIT-1:0]);
  assign doluluk_o     = wr_ptr_q - rd_ptr_q;
  assign yaz_hazir_o   = !dolu_o;
  assign oku_gecerli_o = !bos_o;
  assign oku_veri_o    = bellek[rd_ptr_q[ADRES_BIT-1:0]];
  assign tasma_o       = tasma_q;
  assign alt_tasma_o   = alt_tasma_q;
  assign esik_kesme_o  = esik_kesme_q;

  // Flush wins over both sides; acceptance uses the pre-edge full/empty state.
  assign yaz_kabul = yaz_gecerli_i && !dolu_o && !temizle_i;
  assign oku_kabul = oku_tuket_i && !bos_o && !temizle_i;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{ADRES_BIT{1'b0}}, yaz_kabul};
    rd_ptr_d     = rd_ptr_q + {{ADRES_BIT{1'b0}}, oku_kabul};
    tasma_d      = tasma_q || (yaz_gecerli_i && dolu_o);
    alt_tasma_d  = alt_tasma_q || (oku_tuket_i && bos_o);
    if (temizle_i) begin
      rd_ptr_d    = wr_ptr_q;
      tasma_d     = 1'b0;
      alt_tasma_d = 1'b0;
    end
    doluluk_sonraki = wr_ptr_d - rd_ptr_d;
    esik_kesme_d    = (doluluk_sonraki <= esik_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tasma_q      <= 1'b0;
      alt_tasma_q  <= 1'b0;
      esik_kesme_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tasma_q      <= tasma_d;
      alt_tasma_q  <= alt_tasma_d;
      esik_kesme_q <= esik_kesme_d;
    end
  end

  // Storage has no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (yaz_kabul) begin
      bellek[wr_ptr_q[ADRES_BIT-1:0]] <= yaz_veri_i;
    end
  end

endmodule

// File: tb/tb_uart_verici_kuyrugu.sv
// tb/tb_uart_verici_kuyrugu.sv - directed self-checking bench for uart_verici_kuyrugu
module tb_uart_verici_kuyrugu;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       temizle_i;
  logic       yaz_gecerli_i;
  logic [7:0] yaz_veri_i;
  logic       yaz_hazir_o;
  logic       oku_gecerli_o;
  logic [7:0] oku_veri_o;
  logic       oku_tuket_i;
  logic       bos_o;
  logic       dolu_o;
  logic [4:0] doluluk_o;
  logic [4:0] esik_i;
  logic       esik_kesme_o;
  logic       tasma_o;
  logic       alt_tasma_o;

  int checks   = 0;
  int failures = 0;

  uart_verici_kuyrugu #(.VERI_BIT(8), .DERINLIK(16), .ADRES_BIT(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .temizle_i(temizle_i),
    .yaz_gecerli_i(yaz_gecerli_i), .yaz_veri_i(yaz_veri_i), .yaz_hazir_o(yaz_hazir_o),
    .oku_gecerli_o(oku_gecerli_o), .oku_veri_o(oku_veri_o), .oku_tuket_i(oku_tuket_i),
    .bos_o(bos_o), .dolu_o(dolu_o), .doluluk_o(doluluk_o), .esik_i(esik_i),
    .esik_kesme_o(esik_kesme_o), .tasma_o(tasma_o), .alt_tasma_o(alt_tasma_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    checks++;
    if (gozlenen !== beklenen) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sifir_kontrol(input string etiket);
    kontrol({etiket, "_bos"}, bos_o, 1);
    kontrol({etiket, "_dolu"}, dolu_o, 0);
    kontrol({etiket, "_doluluk"}, doluluk_o, 0);
    kontrol({etiket, "_hazir"}, yaz_hazir_o, 1);
    kontrol({etiket, "_gecerli"}, oku_gecerli_o, 0);
    kontrol({etiket, "_tasma"}, tasma_o, 0);
    kontrol({etiket, "_alt"}, alt_tasma_o, 0);
    kontrol({etiket, "_kesme"}, esik_kesme_o, 0);
  endtask

  initial begin
    rstn_i = 1'b0; temizle_i = 1'b0; yaz_gecerli_i = 1'b0; yaz_veri_i = 8'h00;
    oku_tuket_i = 1'b0; esik_i = 5'd2;
    #12;
    sifir_kontrol("reset");
    rstn_i = 1'b1;
    adim();
    kontrol("idle_kesme", esik_kesme_o, 1);
    kontrol("idle_bos", bos_o, 1);

    // Three pushes then three pops
    yaz_gecerli_i = 1'b1;
    yaz_veri_i = 8'h41; adim();
    kontrol("p1_doluluk", doluluk_o, 1);
    kontrol("p1_gecerli", oku_gecerli_o, 1);
    kontrol("p1_veri", oku_veri_o, 8'h41);
    yaz_veri_i = 8'h42; adim();
    kontrol("p2_doluluk", doluluk_o, 2);
    yaz_veri_i = 8'h43; adim();
    kontrol("p3_doluluk", doluluk_o, 3);
    kontrol("p3_veri", oku_veri_o, 8'h41);
    yaz_gecerli_i = 1'b0; oku_tuket_i = 1'b1;
    adim();
    kontrol("o1_doluluk", doluluk_o, 2);
    kontrol("o1_veri", oku_veri_o, 8'h42);
    adim();
    kontrol("o2_doluluk", doluluk_o, 1);
    kontrol("o2_veri", oku_veri_o, 8'h43);
    adim();
    kontrol("o3_doluluk", doluluk_o, 0);
    kontrol("o3_bos", bos_o, 1);
    oku_tuket_i = 1'b0;
    kontrol("o3_tasma", tasma_o, 0);
    kontrol("o3_alt", alt_tasma_o, 0);

    // Fill, overflow, drain
    yaz_gecerli_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      yaz_veri_i = 8'h10 + 8'(i);
      adim();
    end
    kontrol("full_dolu", dolu_o, 1);
    kontrol("full_hazir", yaz_hazir_o, 0);
    kontrol("full_doluluk", doluluk_o, 16);
    kontrol("full_tasma_once", tasma_o, 0);
    yaz_veri_i = 8'hFF; adim();
    kontrol("ovf_tasma", tasma_o, 1);
    kontrol("ovf_doluluk", doluluk_o, 16);
    yaz_gecerli_i = 1'b0; oku_tuket_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      kontrol("drain_veri", oku_veri_o, 8'h10 + 8'(i));
      adim();
    end
    oku_tuket_i = 1'b0;
    kontrol("drain_bos", bos_o, 1);
    kontrol("drain_tasma_kalici", tasma_o, 1);
    temizle_i = 1'b1; adim(); temizle_i = 1'b0;
    kontrol("flush1_tasma", tasma_o, 0);

    // Simultaneous push/pop with 3 preloaded, across pointer wrap
    yaz_gecerli_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      yaz_veri_i = 8'h60 + 8'(i);
      adim();
    end
    oku_tuket_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kontrol("pp_veri", oku_veri_o, 8'h60 + 8'(i));
      yaz_veri_i = 8'h63 + 8'(i);
      adim();
      kontrol("pp_doluluk", doluluk_o, 3);
    end
    yaz_gecerli_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kontrol("pp_son_veri", oku_veri_o, 8'h88 + 8'(i));
      adim();
    end
    oku_tuket_i = 1'b0;
    kontrol("pp_bos", bos_o, 1);
    kontrol("pp_tasma", tasma_o, 0);
    kontrol("pp_alt", alt_tasma_o, 0);

    // Underflow, then flush with a colliding push and pop
    oku_tuket_i = 1'b1; adim(); oku_tuket_i = 1'b0;
    kontrol("unf_alt", alt_tasma_o, 1);
    kontrol("unf_doluluk", doluluk_o, 0);
    kontrol("unf_bos", bos_o, 1);
    yaz_gecerli_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      yaz_veri_i = 8'hA0 + 8'(i);
      adim();
    end
    kontrol("pre_flush_doluluk", doluluk_o, 5);
    kontrol("pre_flush_veri", oku_veri_o, 8'hA0);
    temizle_i = 1'b1; yaz_veri_i = 8'hAA; oku_tuket_i = 1'b1;
    adim();
    temizle_i = 1'b0; yaz_gecerli_i = 1'b0; oku_tuket_i = 1'b0;
    kontrol("flush_doluluk", doluluk_o, 0);
    kontrol("flush_bos", bos_o, 1);
    kontrol("flush_tasma", tasma_o, 0);
    kontrol("flush_alt", alt_tasma_o, 0);
    adim();
    kontrol("flush_sonra_doluluk", doluluk_o, 0);

    // Low watermark during drain, then asynchronous reset mid-drain
    esik_i = 5'd4; yaz_gecerli_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      yaz_veri_i = 8'hC0 + 8'(i);
      adim();
    end
    yaz_gecerli_i = 1'b0;
    kontrol("esik6_doluluk", doluluk_o, 6);
    kontrol("esik6_kesme", esik_kesme_o, 0);
    oku_tuket_i = 1'b1;
    adim();
    kontrol("esik5_doluluk", doluluk_o, 5);
    kontrol("esik5_kesme", esik_kesme_o, 0);
    adim();
    kontrol("esik4_doluluk", doluluk_o, 4);
    kontrol("esik4_kesme", esik_kesme_o, 1);
    kontrol("esik4_veri", oku_veri_o, 8'hC2);
    #2;
    rstn_i = 1'b0;
    #1;
    sifir_kontrol("async_reset");
    oku_tuket_i = 1'b0;
    adim();
    rstn_i = 1'b1;
    adim();
    kontrol("post_reset_bos", bos_o, 1);
    kontrol("post_reset_alt", alt_tasma_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
